prog_loader: RTL and testbench

- Boot and program-load sequencer for the accumulator CPU.
- Receives a length-prefixed, checksummed byte stream over a valid/ready handshake and writes each byte into the instruction RAM through that RAM's write, writeop and writeaddr path.
- Holds the core in reset for the whole load. Releases it only after the checksum verifies.
- Sits between the host/debug byte source and the CPU top-level program-write and reset inputs.

---
 rtl/prog_loader_if.sv | 26 ++
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream, CPU-control and instruction-RAM write signals of the program loader.
// master = host/debug side, slave = loader.
interface prog_loader_if;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       core_rst;
  logic       write;
  logic [7:0] writeop;
  logic [7:0] writeaddr;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] count;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, core_rst, write, writeop, writeaddr, busy, done, err, count
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, core_rst, write, writeop, writeaddr, busy, done, err, count
  );
endinterface

// File: rtl/prog_loader.sv
// Boot/program-load sequencer: takes a length-prefixed, checksummed byte stream,
// writes it to instruction RAM and releases the core from reset once the checksum matches.
module prog_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  prog_loader_if.slave       bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_SUM  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Timer only needs to reach TIMEOUT-1; the timeout fires on the idle cycle after that.
  localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]    state_q, state_d;
  logic [8:0]    rem_q, rem_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    writeaddr_q, writeaddr_d;
  logic [7:0]    writeop_q, writeop_d;
  logic          write_q, write_d;
  logic [TW-1:0] timer_q, timer_d;

  logic in_ready_w;
  logic accept;
  logic timed_out;

  assign in_ready_w = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_SUM);
  assign accept     = bus.in_valid && in_ready_w;
  assign timed_out  = (TIMEOUT > 0) && in_ready_w && !accept && (timer_q == TLIM);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    count_d     = count_q;
    writeop_d   = writeop_q;
    write_d     = 1'b0;
    // Address advances on the edge that ends each write pulse, so it always
    // shows the address being written and ends one past the last byte.
    writeaddr_d = write_q ? writeaddr_q + 8'd1 : writeaddr_q;
    timer_d     = timer_q;
    if (in_ready_w) begin
      timer_d = accept ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (bus.start) begin
          state_d = S_LEN;
          timer_d = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          rem_d       = (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
          sum_d       = 8'h00;
          count_d     = 8'h00;
          writeaddr_d = 8'h00;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          write_d   = 1'b1;
          writeop_d = bus.in_data;
          count_d   = count_q + 8'd1;
          sum_d     = sum_q + bus.in_data;
          rem_d     = rem_q - 9'd1;
          if (rem_q == 9'd1) begin
            state_d = S_SUM;
          end
        end
      end
      S_SUM: begin
        if (accept) begin
          state_d = (bus.in_data == sum_q) ? S_RUN : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timed_out) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      writeaddr_q <= '0;
      writeop_q   <= '0;
      write_q     <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      writeaddr_q <= writeaddr_d;
      writeop_q   <= writeop_d;
      write_q     <= write_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.busy      = in_ready_w;
  assign bus.done      = (state_q == S_RUN);
  assign bus.err       = (state_q == S_ERR);
  assign bus.core_rst  = (state_q != S_RUN);
  assign bus.write     = write_q;
  assign bus.writeop   = writeop_q;
  assign bus.writeaddr = writeaddr_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected RAM writes queue up as bytes are driven
// and are matched against each observed write pulse.
module tb_prog_loader;
  logic clk;
  logic rst;
  prog_loader_if bus ();

  prog_loader #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] sb[$];
  logic [7:0]  exp_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    $display("[TB] byte 0x%02h accepted", b);
  endtask

  task automatic send_len(input logic [7:0] b);
    exp_addr = 8'h00;
    send_byte(b);
  endtask

  task automatic send_data(input logic [7:0] b);
    sb.push_back({exp_addr, b});
    exp_addr = exp_addr + 8'd1;
    send_byte(b);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_rst"}, {15'd0, bus.core_rst}, 16'd1);
    check({tag, "_write"}, {15'd0, bus.write}, 16'd0);
    check({tag, "_writeop"}, {8'd0, bus.writeop}, 16'h00);
    check({tag, "_writeaddr"}, {8'd0, bus.writeaddr}, 16'h00);
    check({tag, "_in_ready"}, {15'd0, bus.in_ready}, 16'd0);
    check({tag, "_busy"}, {15'd0, bus.busy}, 16'd0);
    check({tag, "_done"}, {15'd0, bus.done}, 16'd0);
    check({tag, "_err"}, {15'd0, bus.err}, 16'd0);
    check({tag, "_count"}, {8'd0, bus.count}, 16'h00);
  endtask

  always @(negedge clk) begin
    if (bus.write === 1'b1) begin
      logic [15:0] e;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL write_extra: observed addr 0x%02h op 0x%02h required no write",
               bus.writeaddr, bus.writeop);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("write_addr_op", {bus.writeaddr, bus.writeop}, e);
        $display("[TB] write addr 0x%02h op 0x%02h", bus.writeaddr, bus.writeop);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish required finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    exp_addr     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_core_rst", {15'd0, bus.core_rst}, 16'd1);

    // Good load
    pulse_start();
    check("len_busy", {15'd0, bus.busy}, 16'd1);
    check("len_in_ready", {15'd0, bus.in_ready}, 16'd1);
    send_len(8'h03);
    send_data(8'h10);
    send_data(8'h25);
    send_data(8'hF0);
    send_byte(8'h25);
    check("good_in_ready", {15'd0, bus.in_ready}, 16'd0);
    check("good_done", {15'd0, bus.done}, 16'd1);
    check("good_core_rst", {15'd0, bus.core_rst}, 16'd0);
    check("good_count", {8'd0, bus.count}, 16'h03);
    check("good_writeaddr", {8'd0, bus.writeaddr}, 16'h03);
    check("good_sb_empty", 16'(sb.size()), 16'd0);

    // Reload from RUN, with a bad checksum
    pulse_start();
    check("reload_core_rst", {15'd0, bus.core_rst}, 16'd1);
    check("reload_busy", {15'd0, bus.busy}, 16'd1);
    check("reload_done", {15'd0, bus.done}, 16'd0);
    send_len(8'h03);
    send_data(8'h10);
    send_data(8'h25);
    send_data(8'hF0);
    send_byte(8'h26);
    check("bad_err", {15'd0, bus.err}, 16'd1);
    check("bad_core_rst", {15'd0, bus.core_rst}, 16'd1);
    check("bad_done", {15'd0, bus.done}, 16'd0);
    check("bad_busy", {15'd0, bus.busy}, 16'd0);

    // Full 256-byte load from ERR with random gaps
    pulse_start();
    check("full_err_cleared", {15'd0, bus.err}, 16'd0);
    send_len(8'h00);
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
      s = s + 8'(i);
      send_data(8'(i));
    end
    check("full_model_sum", {8'd0, s}, 16'h80);
    check("full_not_done_early", {15'd0, bus.done}, 16'd0);
    send_byte(8'h80);
    check("full_done", {15'd0, bus.done}, 16'd1);
    check("full_count", {8'd0, bus.count}, 16'h00);
    check("full_writeaddr", {8'd0, bus.writeaddr}, 16'h00);
    check("full_sb_empty", 16'(sb.size()), 16'd0);

    // Timeout: ERR exactly 16 cycles after the last accept
    pulse_start();
    send_len(8'h04);
    send_data(8'h11);
    send_data(8'h22);
    repeat (15) @(posedge clk);
    #1;
    check("to_not_yet_err", {15'd0, bus.err}, 16'd0);
    check("to_still_busy", {15'd0, bus.busy}, 16'd1);
    @(posedge clk); #1;
    check("to_err", {15'd0, bus.err}, 16'd1);
    check("to_core_rst", {15'd0, bus.core_rst}, 16'd1);
    check("to_in_ready", {15'd0, bus.in_ready}, 16'd0);

    // Byte arriving on the timeout cycle wins
    pulse_start();
    send_len(8'h04);
    send_data(8'h11);
    repeat (15) @(posedge clk);
    #1;
    sb.push_back({exp_addr, 8'h22});
    exp_addr = exp_addr + 8'd1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("edge_no_err", {15'd0, bus.err}, 16'd0);
    check("edge_busy", {15'd0, bus.busy}, 16'd1);
    check("edge_count", {8'd0, bus.count}, 16'h02);
    send_data(8'h33);
    send_data(8'h44);
    send_byte(8'hAA);
    check("edge_done", {15'd0, bus.done}, 16'd1);

    // start during DATA ignored, then async reset mid-load
    pulse_start();
    send_len(8'h05);
    send_data(8'h01);
    send_data(8'h02);
    pulse_start();
    send_data(8'h03);
    check("mid_count", {8'd0, bus.count}, 16'h03);
    check("mid_busy", {15'd0, bus.busy}, 16'd1);
    @(posedge clk); #1;
    check("mid_sb_empty", 16'(sb.size()), 16'd0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Recovery after reset
    pulse_start();
    send_len(8'h01);
    send_data(8'hAB);
    send_byte(8'hAB);
    check("recover_done", {15'd0, bus.done}, 16'd1);
    check("recover_count", {8'd0, bus.count}, 16'h01);
    @(posedge clk); #1;
    check("final_sb_empty", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
